// File: rtl/serieller_schieber.sv
// serieller_schieber: multi-cycle barrel-less shifter/rotator.
// One bit position per clock, counted down from the requested shift count.
// The finished value is copied into a separate result register, so
// Ergebnis only changes when an operation completes or on reset.
// Optional feature macro: SERIELLER_SCHIEBER_ARITH_EN
//   defined   -> Modus 100 is an arithmetic right shift (sign fill)
//   undefined -> Modus 100 is a no-op like 101..111, no sign-fill logic
//
// state    | meaning
// ---------+---------------------------------------------------------------
// LEERLAUF | idle, Bereit=1, waiting for Start
// SCHIEBEN | one position shifted per cycle while the counter runs down;
//          | a zero count spends exactly one cycle here without shifting,
//          | so every request takes at least one cycle to finish
// FERTIG   | Fertig=1 for one cycle, Bereit=1, a new Start is accepted here
module serieller_schieber #(
    parameter int BREITE     = 32,
    parameter int LOG2BREITE = 5
) (
    input  logic                  Takt,
    input  logic                  nReset,
    input  logic                  Start,
    input  logic [BREITE-1:0]     Zahl,
    input  logic [LOG2BREITE-1:0] Stellen,
    input  logic [2:0]            Modus,
    output logic                  Bereit,
    output logic                  Fertig,
    output logic [BREITE-1:0]     Ergebnis
);

    typedef enum logic [1:0] {
        LEERLAUF = 2'd0,
        SCHIEBEN = 2'd1,
        FERTIG   = 2'd2
    } zustand_t;

    localparam logic [2:0] M_ROL = 3'b000;
    localparam logic [2:0] M_ROR = 3'b001;
    localparam logic [2:0] M_SLL = 3'b010;
    localparam logic [2:0] M_SRL = 3'b011;
`ifdef SERIELLER_SCHIEBER_ARITH_EN
    localparam logic [2:0] M_SRA = 3'b100;
`endif

    localparam logic [LOG2BREITE-1:0] ZAEHLER_NULL = '0;
    localparam logic [LOG2BREITE-1:0] ZAEHLER_EINS = {{(LOG2BREITE-1){1'b0}}, 1'b1};

    zustand_t              zustand_q, zustand_d;
    logic [BREITE-1:0]     arbeit_q, arbeit_d;
    logic [BREITE-1:0]     ergebnis_q, ergebnis_d;
    logic [LOG2BREITE-1:0] zaehler_q, zaehler_d;
    logic [2:0]            modus_q, modus_d;
    logic [BREITE-1:0]     geschoben;
    logic                  annahme;

    // One-position shift of the working register according to the latched mode.
    always_comb begin
        geschoben = arbeit_q;
        case (modus_q)
            M_ROL:   geschoben = {arbeit_q[BREITE-2:0], arbeit_q[BREITE-1]};
            M_ROR:   geschoben = {arbeit_q[0], arbeit_q[BREITE-1:1]};
            M_SLL:   geschoben = {arbeit_q[BREITE-2:0], 1'b0};
            M_SRL:   geschoben = {1'b0, arbeit_q[BREITE-1:1]};
`ifdef SERIELLER_SCHIEBER_ARITH_EN
            // The MSB never changes during an arithmetic shift, so the
            // working register's own MSB is the sign latched at acceptance.
            M_SRA:   geschoben = {arbeit_q[BREITE-1], arbeit_q[BREITE-1:1]};
`endif
            default: geschoben = arbeit_q;
        endcase
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        zustand_d  = zustand_q;
        arbeit_d   = arbeit_q;
        ergebnis_d = ergebnis_q;
        zaehler_d  = zaehler_q;
        modus_d    = modus_q;
        Bereit     = (zustand_q != SCHIEBEN);
        Fertig     = (zustand_q == FERTIG);
        annahme    = Start && Bereit;

        case (zustand_q)
            LEERLAUF, FERTIG: begin
                if (annahme) begin
                    arbeit_d  = Zahl;
                    zaehler_d = Stellen;
                    modus_d   = Modus;
                    zustand_d = SCHIEBEN;
                end else if (zustand_q == FERTIG) begin
                    zustand_d = LEERLAUF;
                end
            end
            SCHIEBEN: begin
                if (zaehler_q != ZAEHLER_NULL) begin
                    arbeit_d  = geschoben;
                    zaehler_d = zaehler_q - ZAEHLER_EINS;
                end
                if (zaehler_q <= ZAEHLER_EINS) begin
                    zustand_d  = FERTIG;
                    ergebnis_d = (zaehler_q != ZAEHLER_NULL) ? geschoben : arbeit_q;
                end
            end
            default: begin
                zustand_d = LEERLAUF;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by nReset.
    always_ff @(posedge Takt or negedge nReset) begin
        if (!nReset) begin
            zustand_q  <= LEERLAUF;
            arbeit_q   <= '0;
            ergebnis_q <= '0;
            zaehler_q  <= '0;
            modus_q    <= '0;
        end else begin
            zustand_q  <= zustand_d;
            arbeit_q   <= arbeit_d;
            ergebnis_q <= ergebnis_d;
            zaehler_q  <= zaehler_d;
            modus_q    <= modus_d;
        end
    end

    assign Ergebnis = ergebnis_q;

endmodule

// File: tb/tb_serieller_schieber.sv
// Testbench for serieller_schieber: table-driven vectors plus hand-written
// back-to-back, ignored-Start and reset-abort sequences, with a result
// scoreboard queue filled at Start and drained at Fertig.
module tb_serieller_schieber;

    logic        Takt;
    logic        nReset;
    logic        Start;
    logic [31:0] Zahl;
    logic [4:0]  Stellen;
    logic [2:0]  Modus;
    logic        Bereit;
    logic        Fertig;
    logic [31:0] Ergebnis;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] letztes;

    typedef struct {
        logic [2:0]  modus;
        logic [31:0] zahl;
        logic [4:0]  stellen;
        logic [31:0] erg;
    } vektor_t;

    localparam int NVEK = 16;
    vektor_t vek[NVEK];

    serieller_schieber #(.BREITE(32), .LOG2BREITE(5)) dut (
        .Takt     (Takt),
        .nReset   (nReset),
        .Start    (Start),
        .Zahl     (Zahl),
        .Stellen  (Stellen),
        .Modus    (Modus),
        .Bereit   (Bereit),
        .Fertig   (Fertig),
        .Ergebnis (Ergebnis)
    );

    initial Takt = 1'b0;
    always #5 Takt = ~Takt;

    function automatic logic [31:0] modell(input logic [2:0] m, input logic [31:0] z,
                                           input logic [4:0] s);
        logic [31:0] r;
        int          n;
        n = int'(s);
        case (m)
            3'b000:  r = (z << n) | (z >> (32 - n));
            3'b001:  r = (z >> n) | (z << (32 - n));
            3'b010:  r = z << n;
            3'b011:  r = z >> n;
`ifdef SERIELLER_SCHIEBER_ARITH_EN
            3'b100:  r = $signed(z) >>> n;
`endif
            default: r = z;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] ist, input logic [31:0] soll);
        n_checks++;
        if (ist !== soll) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, ist, soll, $time);
        end
    endtask

    // Called right after the acceptance edge; returns at the negedge where Fertig is seen.
    task automatic warte_fertig(input int soll_lat, input bit stoeren);
        bit got;
        logic [31:0] e;
        got = 1'b0;
        for (int n = 0; n <= 100; n++) begin
            @(negedge Takt);
            if (n == 0) begin
                if (stoeren) begin
                    Start   = 1'b1;
                    Zahl    = 32'hFFFF_FFFF;
                    Modus   = 3'b000;
                    Stellen = 5'd1;
                end else begin
                    Start = 1'b0;
                end
            end
            if (Fertig) begin
                Start = 1'b0;
                got   = 1'b1;
                chk("latenz", n, soll_lat);
                chk("bereit_in_fertig", {31'd0, Bereit}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("scoreboard_leer", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ergebnis", Ergebnis, e);
                    letztes = e;
                end
                break;
            end
            chk("bereit_beim_schieben", {31'd0, Bereit}, 32'd0);
            chk("ergebnis_stabil", Ergebnis, letztes);
            @(posedge Takt);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_fertig: no Fertig within 100 cycles, expected latency %0d", soll_lat);
        end
    endtask

    task automatic run_op(input logic [2:0] m, input logic [31:0] z, input logic [4:0] s,
                          input logic [31:0] erg, input bit stoeren);
        @(negedge Takt);
        chk("bereit_vor_start", {31'd0, Bereit}, 32'd1);
        Start   = 1'b1;
        Zahl    = z;
        Stellen = s;
        Modus   = m;
        exp_q.push_back(erg);
        @(posedge Takt);
        warte_fertig((s == 5'd0) ? 1 : int'(s), stoeren);
        @(posedge Takt);
        @(negedge Takt);
        chk("fertig_ein_takt", {31'd0, Fertig}, 32'd0);
        chk("bereit_nach_fertig", {31'd0, Bereit}, 32'd1);
        chk("ergebnis_gehalten", Ergebnis, erg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vek[0] = '{3'b000, 32'h8000_0001, 5'd1,  32'h0000_0003};
        vek[1] = '{3'b001, 32'h0000_0001, 5'd4,  32'h1000_0000};
`ifdef SERIELLER_SCHIEBER_ARITH_EN
        vek[2] = '{3'b100, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vek[3] = '{3'b100, 32'h4000_0000, 5'd3,  32'h0800_0000};
`else
        vek[2] = '{3'b100, 32'h8000_0000, 5'd31, 32'h8000_0000};
        vek[3] = '{3'b100, 32'h4000_0000, 5'd3,  32'h4000_0000};
`endif
        vek[4] = '{3'b010, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vek[5] = '{3'b011, 32'hF000_0000, 5'd8,  32'h00F0_0000};
        vek[6] = '{3'b010, 32'h0000_000F, 5'd31, 32'h8000_0000};
        vek[7] = '{3'b001, 32'h8000_0001, 5'd31, 32'h0000_0003};
        vek[8] = '{3'b101, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF};
        vek[9] = '{3'b000, 32'h1234_5678, 5'd16, 32'h5678_1234};
        for (int i = 10; i < NVEK; i++) begin
            vek[i].modus   = 3'($urandom_range(0, 7));
            vek[i].zahl    = $urandom;
            vek[i].stellen = 5'($urandom_range(0, 31));
            vek[i].erg     = modell(vek[i].modus, vek[i].zahl, vek[i].stellen);
        end

        Start   = 1'b0;
        Zahl    = '0;
        Stellen = '0;
        Modus   = '0;
        letztes = '0;
        nReset  = 1'b0;
        #1;
        chk("reset_ergebnis", Ergebnis, 32'd0);
        chk("reset_bereit", {31'd0, Bereit}, 32'd1);
        chk("reset_fertig", {31'd0, Fertig}, 32'd0);
        repeat (2) @(posedge Takt);
        @(negedge Takt);
        nReset = 1'b1;

        for (int i = 0; i < NVEK; i++) begin
            run_op(vek[i].modus, vek[i].zahl, vek[i].stellen, vek[i].erg, 1'b0);
        end

        // Start held high with other operands throughout the shift must be ignored.
        run_op(3'b011, 32'hF000_0000, 5'd8, 32'h00F0_0000, 1'b1);

        // Back-to-back: new Start accepted in the FERTIG cycle.
        @(negedge Takt);
        Start = 1'b1; Modus = 3'b010; Zahl = 32'h0000_0001; Stellen = 5'd2;
        exp_q.push_back(32'h0000_0004);
        @(posedge Takt);
        warte_fertig(2, 1'b0);
        Start = 1'b1; Modus = 3'b011; Zahl = 32'h8000_0000; Stellen = 5'd3;
        exp_q.push_back(32'h1000_0000);
        @(posedge Takt);
        warte_fertig(3, 1'b0);
        @(posedge Takt);
        @(negedge Takt);
        chk("b2b_fertig_aus", {31'd0, Fertig}, 32'd0);

        // Reset in the middle of a long shift aborts it without a Fertig pulse.
        @(negedge Takt);
        Start = 1'b1; Modus = 3'b000; Zahl = 32'h0000_0001; Stellen = 5'd10;
        @(posedge Takt);
        @(negedge Takt);
        Start = 1'b0;
        repeat (3) @(posedge Takt);
        @(negedge Takt);
        chk("vor_reset_bereit", {31'd0, Bereit}, 32'd0);
        nReset = 1'b0;
        #1;
        chk("abbruch_ergebnis", Ergebnis, 32'd0);
        chk("abbruch_bereit", {31'd0, Bereit}, 32'd1);
        chk("abbruch_fertig", {31'd0, Fertig}, 32'd0);
        @(posedge Takt);
        @(negedge Takt);
        nReset  = 1'b1;
        letztes = '0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Takt);
            @(negedge Takt);
            chk("kein_fertig_nach_abbruch", {31'd0, Fertig}, 32'd0);
            chk("ergebnis_nach_abbruch", Ergebnis, 32'd0);
        end
        run_op(3'b001, 32'h0000_0003, 5'd2, 32'hC000_0000, 1'b0);

        chk("scoreboard_leer_am_ende", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
